// File: rtl/rv32i_types.sv
// rv32i_types: types shared by the execute stage and its helper units.
// Holds the ALU/branch/mul-div opcode enums, the control word carried with
// each instruction, the stage register bundle and the iterative-unit states.
package rv32i_types;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        md_mul    = 3'b000,
        md_mulh   = 3'b001,
        md_mulhsu = 3'b010,
        md_mulhu  = 3'b011,
        md_div    = 3'b100,
        md_divu   = 3'b101,
        md_rem    = 3'b110,
        md_remu   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_t;

    // mux select encodings
    localparam logic       ALUMUX1_RS1 = 1'b0;
    localparam logic       ALUMUX1_PC  = 1'b1;
    localparam logic [2:0] ALUMUX2_I   = 3'd0;
    localparam logic [2:0] ALUMUX2_U   = 3'd1;
    localparam logic [2:0] ALUMUX2_B   = 3'd2;
    localparam logic [2:0] ALUMUX2_S   = 3'd3;
    localparam logic [2:0] ALUMUX2_J   = 3'd4;
    localparam logic [2:0] ALUMUX2_RS2 = 3'd5;
    localparam logic       CMPMUX_RS2  = 1'b0;
    localparam logic       CMPMUX_I    = 1'b1;

    typedef struct packed {
        alu_ops         aluop;
        branch_funct3_t cmpop;
        logic           alumux1_sel;
        logic [2:0]     alumux2_sel;
        logic           cmpmux_sel;
        logic           md_en;
    } rv32i_control_word;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        rv32i_control_word ctrl;
        logic [2:0]        funct3;
        logic [4:0]        rd;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   i_imm;
        logic [XLEN-1:0]   s_imm;
        logic [XLEN-1:0]   b_imm;
        logic [XLEN-1:0]   u_imm;
        logic [XLEN-1:0]   j_imm;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   br;
    } stage_regs;

endpackage

// File: rtl/alu.sv
// alu: integer ALU. aluop picks the operation on a, b; f is the result.
module alu import rv32i_types::*; #(
    parameter int WIDTH = 32
) (
    input  alu_ops           aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);
    localparam int SW = $clog2(WIDTH);
    logic [SW-1:0] sh;
    assign sh = b[SW-1:0];

    always_comb begin
        f = '0;
        case (aluop)
            alu_add: f = a + b;
            alu_sll: f = a << sh;
            alu_sra: f = $signed(a) >>> sh;
            alu_sub: f = a - b;
            alu_xor: f = a ^ b;
            alu_srl: f = a >> sh;
            alu_or:  f = a | b;
            alu_and: f = a & b;
            default: f = '0;
        endcase
    end
endmodule

// File: rtl/cmp.sv
// cmp: branch comparator. br_en is the outcome of cmpop applied to a, b.
module cmp import rv32i_types::*; #(
    parameter int WIDTH = 32
) (
    input  branch_funct3_t   cmpop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             br_en
);
    always_comb begin
        br_en = 1'b0;
        case (cmpop)
            beq:  br_en = (a == b);
            bne:  br_en = (a != b);
            blt:  br_en = ($signed(a) <  $signed(b));
            bge:  br_en = ($signed(a) >= $signed(b));
            bltu: br_en = (a <  b);
            bgeu: br_en = (a >= b);
            default: br_en = 1'b0;
        endcase
    end
endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 iterative RV32M multiply/divide.
// start latches op/a/b as unsigned magnitudes; WIDTH shift-add or restoring
// subtract steps follow, then one fix-up cycle (done=1) applies signs and the
// divide-by-zero rule and registers result, which holds until the next start.
// Ports: clk, rst_n (async low), kill (abort), start, op, a, b,
//        busy (stepping or fixing), done (fix-up cycle), result.
module muldiv_iter import rv32i_types::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);

    md_op_t           op_q;
    logic [WIDTH-1:0] hi_q, lo_q, dv_q, a_q, result_q;
    logic             neg_q, dz_q, run_q, fix_q;
    logic [CW-1:0]    cnt_q;

    // operand preparation at start
    logic             a_sgn, b_sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    always_comb begin
        a_sgn = (op != md_mulhu) && (op != md_divu) && (op != md_remu);
        b_sgn = a_sgn && (op != md_mulhsu);
        a_neg = a_sgn && a[WIDTH-1];
        b_neg = b_sgn && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // one iteration: shift-add for multiply, restoring subtract for divide
    logic [WIDTH:0] msum, rs, diff;
    always_comb begin
        msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
        rs   = {hi_q, lo_q[WIDTH-1]};
        diff = rs - {1'b0, dv_q};
    end

    // sign correction; remainder takes the dividend's sign, quotient the xor
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_fix;
    always_comb begin
        prod    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo     = neg_q ? -lo_q : lo_q;
        rem     = neg_q ? -hi_q : hi_q;
        res_fix = '0;
        case (op_q)
            md_mul:                       res_fix = prod[WIDTH-1:0];
            md_mulh, md_mulhsu, md_mulhu: res_fix = prod[2*WIDTH-1:WIDTH];
            md_div, md_divu:              res_fix = dz_q ? '1 : quo;
            md_rem, md_remu:              res_fix = dz_q ? a_q : rem;
            default:                      res_fix = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= md_mul;
            hi_q     <= '0;
            lo_q     <= '0;
            dv_q     <= '0;
            a_q      <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            run_q    <= 1'b0;
            fix_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (kill) begin
            run_q <= 1'b0;
            fix_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            op_q  <= op;
            a_q   <= a;
            dz_q  <= (b == '0);
            neg_q <= (op == md_rem || op == md_remu) ? a_neg : (a_neg ^ b_neg);
            hi_q  <= '0;
            // divide: lo = dividend, dv = divisor; multiply: lo = multiplier
            lo_q  <= op[2] ? a_mag : b_mag;
            dv_q  <= op[2] ? b_mag : a_mag;
            cnt_q <= '0;
            run_q <= 1'b1;
            fix_q <= 1'b0;
        end else if (run_q) begin
            if (op_q[2]) begin
                if (!diff[WIDTH]) begin
                    hi_q <= diff[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_q <= rs[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_q <= msum[WIDTH:1];
                lo_q <= {msum[0], lo_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
                run_q <= 1'b0;
                fix_q <= 1'b1;
            end
        end else if (fix_q) begin
            result_q <= res_fix;
            fix_q    <= 1'b0;
        end
    end

    assign busy   = run_q | fix_q;
    assign done   = fix_q;
    assign result = result_q;
endmodule

// File: rtl/mux2.sv
// mux2: two-input selector. sel=0 -> i0, sel=1 -> i1.
module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] f
);
    assign f = sel ? i1 : i0;
endmodule

// File: rtl/mux8.sv
// mux8: eight-input selector indexed by sel.
module mux8 #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i7,
    output logic [WIDTH-1:0] f
);
    always_comb begin
        f = i0;
        case (sel)
            3'd0: f = i0;
            3'd1: f = i1;
            3'd2: f = i2;
            3'd3: f = i3;
            3'd4: f = i4;
            3'd5: f = i5;
            3'd6: f = i6;
            3'd7: f = i7;
            default: f = i0;
        endcase
    end
endmodule

// File: rtl/execute_md.sv
// execute_md: RV32IM execute stage with valid/ready handshakes.
// Non-md ops go through alu/cmp and are registered next edge (full
// throughput). Md ops (MD_EN=1) occupy muldiv_iter; an IDLE/BUSY/DONE FSM
// blocks new input until the result has been loaded into regs_out.
// WIDTH must equal XLEN, since stage_regs fields are XLEN wide.
// Ports: clk, rst_n (async low), in_valid/in_ready/regs_in (upstream),
//        out_valid/out_ready/regs_out (downstream), flush, md_busy.
module execute_md import rv32i_types::*; #(
    parameter int WIDTH = 32,
    parameter int MD_EN = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_valid,
    output logic      in_ready,
    input  stage_regs regs_in,
    output logic      out_valid,
    input  logic      out_ready,
    output stage_regs regs_out,
    input  logic      flush,
    output logic      md_busy
);
    md_state_t state_q, state_d;
    stage_regs md_hold;

    logic             accept, is_md, start, load_alu, load_md, out_free;
    logic             md_done, unit_busy;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH-1:0] alumux1_out, alumux2_out, cmpmux_out, alu_out;
    logic             br_en;

    mux2 #(.WIDTH(WIDTH)) u_alumux1 (
        .sel(regs_in.ctrl.alumux1_sel), .i0(regs_in.rs1), .i1(regs_in.pc), .f(alumux1_out)
    );
    mux8 #(.WIDTH(WIDTH)) u_alumux2 (
        .sel(regs_in.ctrl.alumux2_sel),
        .i0(regs_in.i_imm), .i1(regs_in.u_imm), .i2(regs_in.b_imm), .i3(regs_in.s_imm),
        .i4(regs_in.j_imm), .i5(regs_in.rs2),   .i6('0),            .i7('0),
        .f(alumux2_out)
    );
    mux2 #(.WIDTH(WIDTH)) u_cmpmux (
        .sel(regs_in.ctrl.cmpmux_sel), .i0(regs_in.rs2), .i1(regs_in.i_imm), .f(cmpmux_out)
    );
    alu #(.WIDTH(WIDTH)) u_alu (
        .aluop(regs_in.ctrl.aluop), .a(alumux1_out), .b(alumux2_out), .f(alu_out)
    );
    cmp #(.WIDTH(WIDTH)) u_cmp (
        .cmpop(regs_in.ctrl.cmpop), .a(regs_in.rs1), .b(cmpmux_out), .br_en(br_en)
    );

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state_q == IDLE) && out_free && !flush;
    assign accept   = in_valid && in_ready;
    assign is_md    = (MD_EN != 0) && regs_in.ctrl.md_en;
    assign start    = accept && is_md;
    assign load_alu = accept && !is_md;
    assign load_md  = (state_q == DONE) && out_free;

    generate
        if (MD_EN != 0) begin : g_md
            muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
                .clk(clk), .rst_n(rst_n), .kill(flush), .start(start),
                .op(md_op_t'(regs_in.funct3)), .a(regs_in.rs1), .b(regs_in.rs2),
                .busy(unit_busy), .done(md_done), .result(md_result)
            );
        end else begin : g_no_md
            assign unit_busy = 1'b0;
            assign md_done   = 1'b0;
            assign md_result = '0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = BUSY;
            BUSY:    if (md_done) state_d = DONE;
            DONE:    if (load_md) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    stage_regs alu_pkt, md_pkt;
    always_comb begin
        alu_pkt     = regs_in;
        alu_pkt.alu = alu_out;
        alu_pkt.pc  = alu_out;
        alu_pkt.br  = {{(XLEN-1){1'b0}}, br_en};
        md_pkt      = md_hold;
        md_pkt.alu  = md_result;
        md_pkt.pc   = md_result;
        md_pkt.br   = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            md_hold   <= '0;
            regs_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) md_hold <= regs_in;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load_alu) begin
                regs_out  <= alu_pkt;
                out_valid <= 1'b1;
            end else if (load_md) begin
                regs_out  <= md_pkt;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // unit_busy only ever rises while the FSM is in BUSY
    assign md_busy = (state_q != IDLE) || unit_busy;
endmodule

// File: tb/tb_execute_md.sv
// tb_execute_md: directed vectors with hand-computed results for execute_md.
module tb_execute_md;
    import rv32i_types::*;

    logic      clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, flush = 1'b0;
    logic      in_ready, out_valid, md_busy;
    stage_regs regs_in, regs_out;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] xq[$];

    execute_md #(.WIDTH(32), .MD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .regs_in(regs_in), .out_valid(out_valid), .out_ready(out_ready),
        .regs_out(regs_out), .flush(flush), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // record each output transfer that the coming rising edge will perform
    always @(negedge clk) if (rst_n && out_valid && out_ready) xq.push_back(regs_out.alu);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic stage_regs mk(alu_ops aop, branch_funct3_t cop, logic [2:0] m2, logic m1,
                                     logic cm, logic md, logic [2:0] f3,
                                     logic [31:0] r1, logic [31:0] r2, logic [31:0] imm);
        stage_regs s;
        s = '0;
        s.valid = 1'b1; s.rd = 5'd7; s.pc = 32'h100; s.funct3 = f3;
        s.rs1 = r1; s.rs2 = r2; s.i_imm = imm; s.b_imm = imm;
        s.ctrl.aluop = aop; s.ctrl.cmpop = cop; s.ctrl.alumux1_sel = m1;
        s.ctrl.alumux2_sel = m2; s.ctrl.cmpmux_sel = cm; s.ctrl.md_en = md;
        return s;
    endfunction

    function automatic stage_regs addi(logic [31:0] r1, logic [31:0] imm);
        return mk(alu_add, beq, ALUMUX2_I, ALUMUX1_RS1, CMPMUX_RS2, 1'b0, 3'b000, r1, 32'h0, imm);
    endfunction

    function automatic stage_regs mdop(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        return mk(alu_add, beq, ALUMUX2_RS2, ALUMUX1_RS1, CMPMUX_RS2, 1'b1, f3, a, b, 32'h0);
    endfunction

    // call at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input stage_regs ins);
        int w;
        w = 0;
        in_valid = 1'b1;
        regs_in  = ins;
        #1;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("send_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        send(mdop(f3, a, b));
        chk("md_busy_during", {31'b0, md_busy}, 32'd1);
        chk("md_in_ready_low", {31'b0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        res = regs_out.alu;
        chk("md_pc_eq_result", regs_out.pc, res);
        chk("md_br_zero", regs_out.br, 32'd0);
    endtask

    logic [2:0]  t_f3 [14] = '{3'd1, 3'd3, 3'd0, 3'd2, 3'd4, 3'd6, 3'd4, 3'd6,
                               3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7};
    logic [31:0] t_a  [14] = '{32'h80000000, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF,
                               32'd7, 32'd7, 32'h80000000, 32'h80000000,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd10, 32'd5, 32'd5};
    logic [31:0] t_b  [14] = '{32'h80000000, 32'd2, 32'hFFFFFFFC, 32'd2,
                               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'd2, 32'd2, 32'd3, 32'd3, 32'd0, 32'd0};
    logic [31:0] t_exp[14] = '{32'h40000000, 32'd1, 32'hFFFFFFF4, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0,
                               32'hFFFFFFFD, 32'hFFFFFFFF, 32'h55555555, 32'd1,
                               32'hFFFFFFFF, 32'd5};

    initial begin
        logic [31:0] res;
        int          lat, stray;
        regs_in = '0;

        // asynchronous reset state, before any clock edge
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_md_busy",   {31'b0, md_busy},   32'd0);
        chk("rst_out_alu",   regs_out.alu,       32'd0);
        chk("rst_out_vbit",  {31'b0, regs_out.valid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // ADDI: latency 1
        send(addi(32'd5, 32'd7));
        chk("addi_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_alu", regs_out.alu, 32'd12);
        chk("addi_pc",  regs_out.pc,  32'd12);
        chk("addi_rd",  {27'b0, regs_out.rd}, 32'd7);
        @(posedge clk); #1;
        chk("addi_drained", {31'b0, out_valid}, 32'd0);

        // back-to-back non-md ops at full throughput
        xq.delete();
        send(mk(alu_add, blt, ALUMUX2_B, ALUMUX1_PC, CMPMUX_RS2, 1'b0, 3'b100,
                32'hFFFFFFFF, 32'd1, 32'h20));
        chk("blt_br",  regs_out.br,  32'd1);
        chk("blt_alu", regs_out.alu, 32'h120);
        send(mk(alu_add, bltu, ALUMUX2_B, ALUMUX1_PC, CMPMUX_RS2, 1'b0, 3'b110,
                32'hFFFFFFFF, 32'd1, 32'h20));
        chk("bltu_br", regs_out.br, 32'd0);
        send(mk(alu_sub, beq, ALUMUX2_RS2, ALUMUX1_RS1, CMPMUX_RS2, 1'b0, 3'b000,
                32'd3, 32'd10, 32'd0));
        chk("sub_alu", regs_out.alu, 32'hFFFFFFF9);
        send(mk(alu_and, bge, ALUMUX2_RS2, ALUMUX1_RS1, CMPMUX_I, 1'b0, 3'b101,
                32'hF0, 32'h3C, 32'h10));
        chk("and_alu", regs_out.alu, 32'h30);
        chk("bge_imm_br", regs_out.br, 32'd1);
        @(posedge clk); #1;
        chk("b2b_count", xq.size(), 32'd4);

        // backpressure: 5 stalled cycles, then exactly one transfer each
        out_ready = 1'b0;
        send(addi(32'd100, 32'd1));
        xq.delete();
        in_valid = 1'b1;
        regs_in  = addi(32'd200, 32'd2);
        repeat (5) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_alu",   regs_out.alu, 32'd101);
            chk("stall_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("release_next_alu", regs_out.alu, 32'd202);
        @(posedge clk); #1;
        chk("release_xfers", xq.size(), 32'd2);
        if (xq.size() == 2) begin
            chk("release_first",  xq[0], 32'd101);
            chk("release_second", xq[1], 32'd202);
        end

        // multiply / divide vectors
        for (int i = 0; i < 14; i++) begin
            run_md(t_f3[i], t_a[i], t_b[i], res, lat);
            chk($sformatf("md%0d_f3_%0d_result", i, t_f3[i]), res, t_exp[i]);
            chk($sformatf("md%0d_latency", i), lat, 32'd34);
            @(posedge clk); #1;
        end

        // flush in mid-divide, with an instruction offered in the same cycle
        send(mdop(3'd4, 32'd100, 32'd7));
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        in_valid = 1'b1;
        regs_in = addi(32'd9, 32'd9);
        #1;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_md_busy",   {31'b0, md_busy},   32'd0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        stray = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) stray++; end
        chk("flush_no_result", stray, 32'd0);
        send(addi(32'd1, 32'd2));
        chk("post_flush_valid", {31'b0, out_valid}, 32'd1);
        chk("post_flush_alu", regs_out.alu, 32'd3);
        @(posedge clk); #1;

        // reset in mid-multiply
        send(mdop(3'd0, 32'd6, 32'd7));
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("arst_md_busy",   {31'b0, md_busy},   32'd0);
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_out_alu",   regs_out.alu,       32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        stray = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) stray++; end
        chk("arst_no_result", stray, 32'd0);
        send(addi(32'd20, 32'd22));
        chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("post_rst_alu", regs_out.alu, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
